bitwise_op_exerciser: RTL and testbench

- On-chip stimulus/checker for the pin-level bitwise/arith operand block (operands in, result out).
- Generates pseudo-random operand pairs and an opcode, drives them to the DUT, waits a settle window, then compares the DUT result against an internal golden model.
- Sits opposite the operand block: drives its inputs and consumes its output; reports pass/fail and an error count.

---
 rtl/bitwise_exerciser_pkg.sv | 19 +
 rtl/bitwise_op_exerciser_if.sv | 10 +
 rtl/bitwise_op_exerciser_lfsr16.sv | 17 +
 rtl/bitwise_op_exerciser.sv | 120 ++++++++++++
 tb/tb_bitwise_op_exerciser.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bitwise_exerciser_pkg.sv
// bitwise_exerciser_pkg: shared opcode/state types, LFSR taps and golden model for the exerciser
package bitwise_exerciser_pkg;

    typedef enum logic [1:0] {OP_OR, OP_AND, OP_ADD, OP_XOR} opcode_t;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 as bit positions 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] calc(opcode_t op, logic [7:0] a, logic [7:0] b);
        return op == OP_OR ? a | b : op == OP_AND ? a & b : op == OP_ADD ? a + b : a ^ b;
    endfunction

    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return v == 8'hFF ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bitwise_op_exerciser_if.sv
// bitwise_op_exerciser_if: operand/result bus between the exerciser (master) and the operand block (slave)
interface bitwise_op_exerciser_if;
    import bitwise_exerciser_pkg::*;
    logic [7:0] op_a;
    logic [7:0] op_b;
    opcode_t    op_sel;
    logic [7:0] result_in;
    modport master (output op_a, output op_b, output op_sel, input result_in);
    modport slave (input op_a, input op_b, input op_sel, output result_in);
endinterface

// File: rtl/bitwise_op_exerciser_lfsr16.sv
// lfsr16: 16-bit left-shifting Fibonacci LFSR with seed load and step enable
module lfsr16
    import bitwise_exerciser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);
    // reset and load both restart the sequence from the seed; feedback enters bit 0
    always_ff @(posedge clk) begin
        if (rst || load) q <= seed;
        else if (step) q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
endmodule

// File: rtl/bitwise_op_exerciser.sv
// bitwise_op_exerciser: drives LFSR operand pairs to the operand block and checks its results.
// Define BITWISE_EXERCISER_FAIL_CAPTURE_EN to add capture of the first mismatching vector.
module bitwise_op_exerciser
    import bitwise_exerciser_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          N_VECTORS = 64,
    parameter int          SETTLE    = 2,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    bitwise_op_exerciser_if.master       bus,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   err_count
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
    ,
    output logic                         fail_valid,
    output logic [7:0]                   fail_a,
    output logic [7:0]                   fail_b,
    output logic [7:0]                   fail_got
`endif
);
    state_t           state;
    logic [15:0]      vec_cnt;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] expected;
    logic [15:0]      lfsr;
    logic             accept;
    logic             last;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = vec_cnt == 16'(N_VECTORS - 1);
    assign pass   = done && err_count == 8'd0;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .seed (SEED),
        .step (state == S_CHECK && !last),
        .q    (lfsr)
    );

    // run sequencer: drive a vector, let it settle, compare, repeat until the last vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bus.op_a   <= '0;
            bus.op_b   <= '0;
            bus.op_sel <= OP_OR;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            vec_cnt    <= '0;
            settle_cnt <= '0;
            expected   <= '0;
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    bus.op_sel <= opcode_t'(mode);
                    err_count  <= '0;
                    vec_cnt    <= '0;
                    done       <= 1'b0;
                    busy       <= 1'b1;
                    state      <= S_DRIVE;
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
                    fail_valid <= 1'b0;
                    fail_a     <= '0;
                    fail_b     <= '0;
                    fail_got   <= '0;
`endif
                end
                S_DRIVE: begin
                    bus.op_a   <= lfsr[15:8];
                    bus.op_b   <= lfsr[7:0];
                    expected   <= calc(bus.op_sel, lfsr[15:8], lfsr[7:0]);
                    settle_cnt <= 4'(SETTLE - 1);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (settle_cnt == 4'd0) state <= S_CHECK;
                    else settle_cnt <= settle_cnt - 4'd1;
                end
                S_CHECK: begin
                    if (bus.result_in != expected) begin
                        err_count <= sat_inc(err_count);
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= bus.op_a;
                            fail_b     <= bus.op_b;
                            fail_got   <= bus.result_in;
                        end
`endif
                    end
                    if (last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        vec_cnt <= vec_cnt + 16'd1;
                        state   <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitwise_op_exerciser.sv
// tb_bitwise_op_exerciser: runs three exerciser instances against a faultable operand-block model
module tb_bitwise_op_exerciser;
    import bitwise_exerciser_pkg::*;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [2:0] st = 3'd0;
    logic [2:0] bsy, dn, ps;
    logic [7:0] ec [3];
    logic [7:0] oa [3];
    logic [7:0] ob [3];
    logic [7:0] rr [3];
    logic [1:0] os [3];
    int         fault_kind = 0;
    logic [2:0] fault_bit = 3'd0;
    logic       fault_pol = 1'b0;
    int         checks = 0;
    int         errors = 0;
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
    logic [2:0] fv;
    logic [7:0] fa [3];
    logic [7:0] fb [3];
    logic [7:0] fg [3];
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return 8'((int'(a) + int'(b)) % 256);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [15:0] ref_adv(logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // operand block model: 0 ideal, 1 one bit stuck, 2 always inverted, 3 always OR
    function automatic logic [7:0] block(logic [1:0] op, logic [7:0] a, logic [7:0] b,
                                         int kind, logic [2:0] bi, logic pol);
        logic [7:0] g;
        g = ref_op(op, a, b);
        if (kind == 1) g[bi] = pol;
        if (kind == 2) g = ~g;
        if (kind == 3) g = a | b;
        return g;
    endfunction

    bitwise_op_exerciser_if i4 ();
    bitwise_op_exerciser_if i64 ();
    bitwise_op_exerciser_if i300 ();

    assign i4.result_in   = block(i4.op_sel, i4.op_a, i4.op_b, fault_kind, fault_bit, fault_pol);
    assign i64.result_in  = block(i64.op_sel, i64.op_a, i64.op_b, fault_kind, fault_bit, fault_pol);
    assign i300.result_in = block(i300.op_sel, i300.op_a, i300.op_b, fault_kind, fault_bit, fault_pol);
    assign oa[0] = i4.op_a;
    assign ob[0] = i4.op_b;
    assign rr[0] = i4.result_in;
    assign os[0] = i4.op_sel;
    assign oa[1] = i64.op_a;
    assign ob[1] = i64.op_b;
    assign rr[1] = i64.result_in;
    assign os[1] = i64.op_sel;
    assign oa[2] = i300.op_a;
    assign ob[2] = i300.op_b;
    assign rr[2] = i300.result_in;
    assign os[2] = i300.op_sel;

    bitwise_op_exerciser #(.N_VECTORS(4), .SETTLE(2), .SEED(SEED)) u4 (
        .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .bus(i4.master),
        .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .err_count(ec[0])
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
        , .fail_valid(fv[0]), .fail_a(fa[0]), .fail_b(fb[0]), .fail_got(fg[0])
`endif
    );

    bitwise_op_exerciser #(.N_VECTORS(64), .SETTLE(2), .SEED(SEED)) u64 (
        .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .bus(i64.master),
        .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .err_count(ec[1])
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
        , .fail_valid(fv[1]), .fail_a(fa[1]), .fail_b(fb[1]), .fail_got(fg[1])
`endif
    );

    bitwise_op_exerciser #(.N_VECTORS(300), .SETTLE(2), .SEED(SEED)) u300 (
        .clk(clk), .rst(rst), .start(st[2]), .mode(mode), .bus(i300.master),
        .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .err_count(ec[2])
`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
        , .fail_valid(fv[2]), .fail_a(fa[2]), .fail_b(fb[2]), .fail_got(fg[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // start a run on instance id; cyc counts edges from the accepting edge until done is seen
    task automatic run(input int id, input logic [1:0] m, input bit ign, output int cyc,
                       output logic [7:0] a0, output logic [7:0] b0, output logic [7:0] r0);
        @(negedge clk);
        mode = m;
        st[id] = 1'b1;
        @(negedge clk);
        st[id] = 1'b0;
        cyc = 1;
        a0 = '0;
        b0 = '0;
        r0 = '0;
        while (!dn[id] && cyc < 5000) begin
            st[id] = ign && (cyc == 1 || cyc == 3);
            mode = st[id] ? 2'd3 : m;
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                a0 = oa[id];
                b0 = ob[id];
                r0 = rr[id];
            end
        end
        st[id] = 1'b0;
        mode = m;
    endtask

    function automatic int stuck_errs(logic [1:0] m, int n, int kind, logic [2:0] bi, logic pol);
        logic [15:0] s;
        logic [7:0]  g;
        int          e;
        s = SEED;
        e = 0;
        for (int k = 0; k < n; k++) begin
            g = ref_op(m, s[15:8], s[7:0]);
            if (kind == 1 && g[bi] != pol) e++;
            s = ref_adv(s);
        end
        return e;
    endfunction

    initial begin
        int          cyc;
        int          exp_e;
        logic [7:0]  a0, b0, r0;
        logic [15:0] s;
        logic [1:0]  m;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_op_a", oa[0], 8'h00);
        check("rst_op_b", ob[0], 8'h00);
        check("rst_op_sel", os[0], 2'd0);
        check("rst_busy", bsy[0], 1'b0);
        check("rst_done", dn[0], 1'b0);
        check("rst_err", ec[0], 8'd0);
        check("rst_pass", ps[0], 1'b0);

        run(0, 2'd0, 1'b0, cyc, a0, b0, r0);
        check("or_first_a", a0, 8'hAC);
        check("or_first_b", b0, 8'hE1);
        check("or_first_res", r0, 8'hED);
        check("or_cycles", cyc, 17);
        check("or_done", dn[0], 1'b1);
        check("or_busy", bsy[0], 1'b0);
        check("or_pass", ps[0], 1'b1);
        check("or_err", ec[0], 8'd0);
        s = SEED;
        repeat (3) s = ref_adv(s);
        check("or_hold_a", oa[0], {24'd0, s[15:8]});
        check("or_hold_b", ob[0], {24'd0, s[7:0]});

        run(0, 2'd2, 1'b0, cyc, a0, b0, r0);
        check("add_first_res", r0, 8'h8D);
        check("add_pass", ps[0], 1'b1);
        check("add_op_sel", os[0], 2'd2);
        run(0, 2'd3, 1'b0, cyc, a0, b0, r0);
        check("xor_first_res", r0, 8'h4D);
        check("xor_pass", ps[0], 1'b1);

        run(0, 2'd0, 1'b1, cyc, a0, b0, r0);
        check("ign_cycles", cyc, 17);
        check("ign_op_sel", os[0], 2'd0);
        check("ign_first_res", r0, 8'hED);
        check("ign_pass", ps[0], 1'b1);

        @(negedge clk);
        mode = 2'd1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", bsy[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", bsy[0], 1'b0);
        check("mid_rst_done", dn[0], 1'b0);
        check("mid_rst_op_a", oa[0], 8'h00);
        check("mid_rst_op_b", ob[0], 8'h00);
        check("mid_rst_op_sel", os[0], 2'd0);
        check("mid_rst_err", ec[0], 8'd0);
        check("mid_rst_pass", ps[0], 1'b0);
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", dn[0], 1'b0);

        fault_kind = 1;
        fault_bit = 3'd0;
        fault_pol = 1'b0;
        exp_e = stuck_errs(2'd0, 64, 1, 3'd0, 1'b0);
        run(1, 2'd0, 1'b0, cyc, a0, b0, r0);
        check("stuck0_err", ec[1], exp_e);
        check("stuck0_pass", ps[1], 1'b0);
        check("stuck0_cycles", cyc, 257);

        for (int r = 0; r < 4; r++) begin
            m = 2'($urandom_range(0, 3));
            fault_kind = int'($urandom_range(0, 1));
            fault_bit = 3'($urandom_range(0, 7));
            fault_pol = 1'($urandom_range(0, 1));
            exp_e = stuck_errs(m, 64, fault_kind, fault_bit, fault_pol);
            run(1, m, 1'b0, cyc, a0, b0, r0);
            check("rand_err", ec[1], exp_e);
            check("rand_pass", ps[1], exp_e == 0);
            check("rand_done", dn[1], 1'b1);
        end

        fault_kind = 2;
        run(2, 2'($urandom_range(0, 3)), 1'b0, cyc, a0, b0, r0);
        check("sat_err", ec[2], 8'd255);
        check("sat_done", dn[2], 1'b1);
        check("sat_pass", ps[2], 1'b0);
        check("sat_cycles", cyc, 1201);

`ifdef BITWISE_EXERCISER_FAIL_CAPTURE_EN
        fault_kind = 3;
        run(0, 2'd1, 1'b0, cyc, a0, b0, r0);
        check("cap_valid", fv[0], 1'b1);
        check("cap_a", fa[0], 8'hAC);
        check("cap_b", fb[0], 8'hE1);
        check("cap_got", fg[0], 8'hED);
        fault_kind = 0;
        run(0, 2'd1, 1'b0, cyc, a0, b0, r0);
        check("cap_cleared", fv[0], 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
